uart_rx_controller: RTL and testbench

- Sequences UART receive: synchronises the serial line, samples start/data/stop bits at mid-bit, assembles bytes and buffers them in a small FIFO.
- Serves the CPU's memory-mapped UART read through a blocking request/acknowledge handshake. A pending load stalls the pipeline until a byte is available, so the destination register stays unchanged until then.
- Sits between the SoC `uart_rx` pin and the SoC's I/O bus decode.

---
 rtl/uart_rx_pkg.sv | 15 +
 rtl/uart_rx_fifo.sv | 53 +++++
 rtl/uart_rx_controller.sv | 202 ++++++++++++++++++++
 tb/tb_uart_rx_controller.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path (uart_rx_fifo, uart_rx_controller).
package uart_rx_pkg;

    localparam int unsigned DATA_BITS   = 8;
    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Circular byte buffer with extra-MSB pointers; a push while full is accepted only alongside a pop.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_BITS-1:0]     push_data,
    input  logic                     pop,
    output logic [DATA_BITS-1:0]     pop_data,
    output logic [FIFO_DEPTH_LOG2:0] count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PTR_W = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;

    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [PTR_W-1:0]     r_count;
    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic                 w_do_push;
    logic                 w_do_pop;

    assign full      = (r_wptr[PTR_W-1] != r_rptr[PTR_W-1]) &&
                       (r_wptr[PTR_W-2:0] == r_rptr[PTR_W-2:0]);
    assign empty     = (r_wptr == r_rptr);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign pop_data  = r_mem[r_rptr[PTR_W-2:0]];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + PTR_W'(1);
            else if (!w_do_push && w_do_pop) r_count <= r_count - PTR_W'(1);
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[PTR_W-2:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx_controller.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM, byte FIFO and blocking read handshake.
// Defining UART_RX_PARITY_EN adds an even-parity bit per frame and the sticky parity_err output.
module uart_rx_controller
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ        = 50_000_000,
    parameter int unsigned BAUD_RATE       = 25_000_000,
    parameter int unsigned TICKS_PER_BIT   = CLK_FREQ / BAUD_RATE,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     uart_rx,
    input  logic                     rd_req,
    output logic                     rd_ack,
    output logic [DATA_BITS-1:0]     rd_data,
    output logic [FIFO_DEPTH_LOG2:0] rx_count,
    output logic                     overrun,
    output logic                     frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                     parity_err,
`endif
    input  logic                     clr_err
);
    localparam int unsigned       TICK_W    = $clog2(TICKS_PER_BIT);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(TICKS_PER_BIT / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_FULL = TICK_W'(TICKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    rx_state_e              r_state, w_state_nxt;
    logic [TICK_W-1:0]      r_tick, w_tick_nxt;
    logic [2:0]             r_bit, w_bit_nxt;
    logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
    logic                   r_push, w_push_nxt;
    logic [DATA_BITS-1:0]   r_push_data, w_push_data_nxt;
    logic                   r_ack, w_ack_nxt;
    logic [DATA_BITS-1:0]   r_rd_data, w_rd_data_nxt;
    logic                   r_overrun, w_overrun_nxt;
    logic                   r_frame_err, w_frame_err_nxt;
`ifdef UART_RX_PARITY_EN
    logic                   r_par_bad, w_par_bad_nxt;
    logic                   r_parity_err, w_parity_err_nxt;
`endif
    logic                   w_line;
    logic                   w_tick_done;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [DATA_BITS-1:0]   w_pop_data;
    logic [FIFO_DEPTH_LOG2:0] w_count;

    assign w_line      = r_sync[SYNC_STAGES-1];
    assign w_tick_done = (r_tick == '0);

    uart_rx_fifo #(.FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_push),
        .push_data (r_push_data),
        .pop       (w_pop),
        .pop_data  (w_pop_data),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync       <= '1;
            r_state      <= IDLE;
            r_tick       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_push       <= 1'b0;
            r_push_data  <= '0;
            r_ack        <= 1'b0;
            r_rd_data    <= '0;
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_sync       <= {r_sync[SYNC_STAGES-2:0], uart_rx};
            r_state      <= w_state_nxt;
            r_tick       <= w_tick_nxt;
            r_bit        <= w_bit_nxt;
            r_shift      <= w_shift_nxt;
            r_push       <= w_push_nxt;
            r_push_data  <= w_push_data_nxt;
            r_ack        <= w_ack_nxt;
            r_rd_data    <= w_rd_data_nxt;
            r_overrun    <= w_overrun_nxt;
            r_frame_err  <= w_frame_err_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= w_par_bad_nxt;
            r_parity_err <= w_parity_err_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_tick_nxt       = r_tick;
        w_bit_nxt        = r_bit;
        w_shift_nxt      = r_shift;
        w_push_nxt       = 1'b0;
        w_push_data_nxt  = r_push_data;
        w_frame_err_nxt  = clr_err ? 1'b0 : r_frame_err;
        w_overrun_nxt    = clr_err ? 1'b0 : r_overrun;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt    = r_par_bad;
        w_parity_err_nxt = clr_err ? 1'b0 : r_parity_err;
`endif

        // Receive sequencing; the tick counter counts down to the next mid-bit sample.
        case (r_state)
            IDLE: begin
                if (!w_line) begin
                    w_state_nxt = START;
                    w_tick_nxt  = TICK_HALF;
                end
            end
            START: begin
                if (!w_tick_done) begin
                    w_tick_nxt = r_tick - TICK_W'(1);
                end else if (!w_line) begin
                    w_state_nxt = DATA;
                    w_bit_nxt   = '0;
                    w_tick_nxt  = TICK_FULL;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            DATA: begin
                if (!w_tick_done) begin
                    w_tick_nxt = r_tick - TICK_W'(1);
                end else begin
                    w_shift_nxt = {w_line, r_shift[DATA_BITS-1:1]};
                    w_tick_nxt  = TICK_FULL;
                    w_bit_nxt   = r_bit + 3'(1);
                    if (r_bit == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (!w_tick_done) begin
                    w_tick_nxt = r_tick - TICK_W'(1);
                end else begin
                    w_par_bad_nxt = (w_line != ^r_shift);
                    if (w_line != ^r_shift) w_parity_err_nxt = 1'b1;
                    w_tick_nxt  = TICK_FULL;
                    w_state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (!w_tick_done) begin
                    w_tick_nxt = r_tick - TICK_W'(1);
                end else begin
                    w_state_nxt = IDLE;
                    if (!w_line) begin
                        w_frame_err_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (!r_par_bad) begin
`else
                    end else begin
`endif
                        w_push_nxt      = 1'b1;
                        w_push_data_nxt = r_shift;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Read handshake: one pop per ack, ack forced low the cycle after.
        w_pop         = rd_req && !r_ack && !w_empty;
        w_ack_nxt     = w_pop;
        w_rd_data_nxt = w_pop ? w_pop_data : r_rd_data;

        if (r_push && w_full && !w_pop) w_overrun_nxt = 1'b1;
    end

    assign rd_ack     = r_ack;
    assign rd_data    = r_rd_data;
    assign rx_count   = w_count;
    assign overrun    = r_overrun;
    assign frame_err  = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx_controller.sv
// Self-checking bench for uart_rx_controller: directed scenarios plus randomized byte bursts
// checked against a queue-based model of the receive buffer and sticky flags.
module tb_uart_rx_controller;

    localparam int unsigned TPB   = 2;
    localparam int unsigned DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    // Start edge reaches the FSM after 2 sync flops (+1 edge to act), start is sampled TPB/2
    // later, stop another (FRAME_BITS-1) bit times later, then push (+1) and ack (+1).
    localparam int unsigned LAT = 3 + TPB / 2 + (FRAME_BITS - 1) * TPB + 2;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       uart_rx = 1'b1;
    logic       rd_req  = 1'b0;
    logic       clr_err = 1'b0;
    logic       rd_ack;
    logic [7:0] rd_data;
    logic [2:0] rx_count;
    logic       overrun;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int n_vec   = 0;
    int n_err   = 0;
    int cyc     = 0;
    int ack_cnt = 0;
    int ack_cyc = 0;

    logic [7:0] exp_q[$];
    logic       exp_ovr;
    logic       exp_ferr;

    uart_rx_controller #(
        .CLK_FREQ        (50_000_000),
        .BAUD_RATE       (25_000_000),
        .FIFO_DEPTH_LOG2 (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .rd_req     (rd_req),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .rx_count   (rx_count),
        .overrun    (overrun),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rd_ack) begin
            ack_cnt = ack_cnt + 1;
            ack_cyc = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "bench timed out");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] d, input logic stop_bit, input int nbits);
        logic fr [FRAME_BITS];
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[i+1] = d[i];
`ifdef UART_RX_PARITY_EN
        fr[9] = ^d;
`endif
        fr[FRAME_BITS-1] = stop_bit;
        for (int i = 0; i < nbits; i++) begin
            uart_rx = fr[i];
            step(TPB);
        end
        uart_rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic good);
        send_bits(d, good, FRAME_BITS);
        step(TPB);
        if (!good)                  exp_ferr = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else                        exp_ovr = 1'b1;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, "_count"},   32'(rx_count),  32'(exp_q.size()));
        check_eq({tag, "_overrun"}, 32'(overrun),   32'(exp_ovr));
        check_eq({tag, "_frame"},   32'(frame_err), 32'(exp_ferr));
`ifdef UART_RX_PARITY_EN
        check_eq({tag, "_parity"},  32'(parity_err), 32'(0));
`endif
    endtask

    task automatic read_expect(input string tag);
        logic [7:0] e;
        int waited;
        waited = 0;
        e = exp_q.pop_front();
        rd_req = 1'b1;
        do begin
            @(negedge clk);
            waited++;
        end while (!rd_ack && waited < 200);
        rd_req = 1'b0;
        check_eq({tag, "_ack"}, 32'(rd_ack), 32'(1));
        check_eq({tag, "_data"}, 32'(rd_data), 32'(e));
        @(negedge clk);
        check_eq({tag, "_pulse"}, 32'(rd_ack), 32'(0));
        step(1);
    endtask

    task automatic clear_errs();
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
    endtask

    initial begin
        int k;
        int a0;
        int nb;
        int nr;
        logic [7:0] d;
        logic good;

        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;

        // Reset values
        step(3);
        check_eq("rst_ack",   32'(rd_ack),    32'(0));
        check_eq("rst_data",  32'(rd_data),   32'(0));
        check_eq("rst_count", 32'(rx_count),  32'(0));
        check_eq("rst_ovr",   32'(overrun),   32'(0));
        check_eq("rst_ferr",  32'(frame_err), 32'(0));
        rst = 1'b1;
        step(2);

        // Pending read from before the frame: ack exactly LAT cycles after the start edge
        rd_req = 1'b1;
        k  = cyc;
        a0 = ack_cnt;
        send_bits(8'h55, 1'b1, FRAME_BITS);
        check_eq("t1_no_early_ack", 32'(ack_cnt - a0), 32'(0));
        step(8);
        rd_req = 1'b0;
        check_eq("t1_ack_count", 32'(ack_cnt - a0), 32'(1));
        check_eq("t1_latency",   32'(ack_cyc - k),  32'(LAT));
        check_eq("t1_data",      32'(rd_data),      32'(8'h55));
        check_eq("t1_count",     32'(rx_count),     32'(0));
        step(2);

        // Two buffered bytes, read in order
        send_byte(8'h55, 1'b1);
        send_byte(8'hA3, 1'b1);
        step(4);
        check_state("t2_buf");
        read_expect("t2_rd0");
        read_expect("t2_rd1");
        check_state("t2_after");

        // Overrun on the fifth byte
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        step(4);
        check_state("t3_full");
        for (int i = 0; i < 4; i++) read_expect("t3_rd");
        clear_errs();
        check_state("t3_clr");

        // Framing error then a good byte
        send_byte(8'h7E, 1'b0);
        step(4);
        check_state("t4_ferr");
        send_byte(8'h42, 1'b1);
        step(4);
        check_state("t4_next");
        read_expect("t4_rd");
        clear_errs();

        // One-cycle glitch while idle
        send_byte(8'h11, 1'b1);
        step(4);
        uart_rx = 1'b0;
        step(1);
        uart_rx = 1'b1;
        step(8);
        check_state("t5_glitch");

        // Reset in the middle of the data bits
        send_bits(8'hC9, 1'b1, 5);
        rst = 1'b0;
        uart_rx = 1'b1;
        step(1);
        check_eq("t6_rst_ack",   32'(rd_ack),    32'(0));
        check_eq("t6_rst_data",  32'(rd_data),   32'(0));
        check_eq("t6_rst_count", 32'(rx_count),  32'(0));
        check_eq("t6_rst_ovr",   32'(overrun),   32'(0));
        check_eq("t6_rst_ferr",  32'(frame_err), 32'(0));
        step(2);
        rst = 1'b1;
        exp_q.delete();
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        step(2);
        send_byte(8'h33, 1'b1);
        step(4);
        check_state("t6_after");
        read_expect("t6_rd");

        // Randomized bursts with occasional bad stop bits and partial drains
        for (int r = 0; r < 20; r++) begin
            nb = int'($urandom_range(5, 1));
            for (int b = 0; b < nb; b++) begin
                d    = 8'($urandom);
                good = ($urandom_range(7, 0) != 0);
                send_byte(d, good);
            end
            step(4);
            check_state("rnd_buf");
            nr = int'($urandom_range(exp_q.size(), 0));
            for (int i = 0; i < nr; i++) read_expect("rnd_rd");
            check_state("rnd_drain");
            if ($urandom_range(2, 0) == 0) clear_errs();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
